// File: rtl/lockout_guard.sv
`default_nettype none
// ============================================================================
//  Module   : lockout_guard
//  Brief    : Brute-force guard between the Open_Close button and lock control;
//             escalating timed lockout after repeated failed entries.
//  Revision : 1.0
// ============================================================================
module lockout_guard #(
    parameter int MAX_FAILS   = 3,
    parameter int TICK_DIV    = 100_000_000,
    parameter int LOCKOUT_SEC = 30,
    parameter int BLINK_DIV   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_open_close,
    input  logic [2:0] i_selector,
    input  logic       i_alarm,
    output logic       o_open_close,
    output logic       o_alarm,
    output logic       o_lockout,
    output logic       o_release,
    output logic [7:0] o_seconds_left,
    output logic [3:0] o_fail_count,
    output logic [1:0] o_lockout_level
);

    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [TW-1:0] C_TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [4:0]    C_MAX_FAILS  = 5'(MAX_FAILS);
    localparam logic [7:0]    C_BASE_SEC   = 8'(LOCKOUT_SEC);
    localparam logic [2:0]    C_SEL_FAIL   = 3'b111;
    localparam logic [2:0]    C_SEL_PASS   = 3'b110;

    typedef enum logic [0:0] {
        S_NORMAL  = 1'b0,
        S_LOCKOUT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_sel_q;
    logic [3:0]      r_fail_cnt,  w_fail_cnt_nxt;
    logic [1:0]      r_level,     w_level_nxt;
    logic [7:0]      r_secs,      w_secs_nxt;
    logic [TW-1:0]   r_presc,     w_presc_nxt;
    logic [BW-1:0]   r_blink_cnt, w_blink_cnt_nxt;
    logic            r_blink_ph,  w_blink_ph_nxt;
    logic            r_oc,        w_oc_nxt;
    logic            r_release,   w_release_nxt;

    logic            w_fail_edge;
    logic            w_pass_edge;
    logic            w_trigger;

    assign w_fail_edge = (i_selector == C_SEL_FAIL) && (r_sel_q != C_SEL_FAIL);
    assign w_pass_edge = (i_selector == C_SEL_PASS) && (r_sel_q != C_SEL_PASS);
    assign w_trigger   = w_fail_edge && (({1'b0, r_fail_cnt} + 5'd1) == C_MAX_FAILS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_NORMAL;
            r_sel_q     <= 3'b000;
            r_fail_cnt  <= 4'd0;
            r_level     <= 2'd0;
            r_secs      <= 8'd0;
            r_presc     <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
            r_oc        <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel_q     <= i_selector;
            r_fail_cnt  <= w_fail_cnt_nxt;
            r_level     <= w_level_nxt;
            r_secs      <= w_secs_nxt;
            r_presc     <= w_presc_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_ph  <= w_blink_ph_nxt;
            r_oc        <= w_oc_nxt;
            r_release   <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_fail_cnt_nxt  = r_fail_cnt;
        w_level_nxt     = r_level;
        w_secs_nxt      = r_secs;
        w_presc_nxt     = '0;
        w_blink_cnt_nxt = '0;
        w_blink_ph_nxt  = 1'b1;
        w_oc_nxt        = 1'b0;
        w_release_nxt   = 1'b0;

        case (r_state)
            S_NORMAL: begin
                w_oc_nxt = i_open_close & ~w_trigger;
                if (w_fail_edge) begin
                    if (w_trigger) begin
                        // Duration uses the level before this lockout escalates it
                        w_state_nxt    = S_LOCKOUT;
                        w_fail_cnt_nxt = 4'd0;
                        w_secs_nxt     = C_BASE_SEC << r_level;
                        w_level_nxt    = (r_level == 2'd3) ? 2'd3 : r_level + 2'd1;
                    end else begin
                        w_fail_cnt_nxt = r_fail_cnt + 4'd1;
                    end
                end else if (w_pass_edge) begin
                    w_fail_cnt_nxt = 4'd0;
                    w_level_nxt    = 2'd0;
                end
            end

            S_LOCKOUT: begin
                if (r_blink_cnt == C_BLINK_LAST) begin
                    w_blink_cnt_nxt = '0;
                    w_blink_ph_nxt  = ~r_blink_ph;
                end else begin
                    w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                    w_blink_ph_nxt  = r_blink_ph;
                end

                if (r_presc == C_TICK_LAST) begin
                    w_presc_nxt = '0;
                    if (r_secs <= 8'd1) begin
                        w_secs_nxt      = 8'd0;
                        w_state_nxt     = S_NORMAL;
                        w_release_nxt   = 1'b1;
                        w_blink_cnt_nxt = '0;
                        w_blink_ph_nxt  = 1'b1;
                    end else begin
                        w_secs_nxt = r_secs - 8'd1;
                    end
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_NORMAL;
            end
        endcase
    end

    assign o_open_close    = r_oc;
    assign o_lockout       = (r_state == S_LOCKOUT);
    assign o_release       = r_release;
    assign o_seconds_left  = r_secs;
    assign o_fail_count    = r_fail_cnt;
    assign o_lockout_level = r_level;
    assign o_alarm         = i_alarm | (o_lockout & r_blink_ph);

endmodule
`default_nettype wire

// File: tb/tb_lockout_guard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lockout_guard
//  Brief    : Directed and randomized checks of lockout_guard against a
//             cycle-level behavioural model.
//  Revision : 1.0
// ============================================================================
module tb_lockout_guard;

    localparam int C_MAX_FAILS = 3;
    localparam int C_TICK_DIV  = 4;
    localparam int C_LOCK_SEC  = 2;
    localparam int C_BLINK_DIV = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_open_close = 1'b0;
    logic [2:0] i_selector = 3'b000;
    logic       i_alarm = 1'b0;
    logic       o_open_close;
    logic       o_alarm;
    logic       o_lockout;
    logic       o_release;
    logic [7:0] o_seconds_left;
    logic [3:0] o_fail_count;
    logic [1:0] o_lockout_level;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: lockout tracked as elapsed cycles against a total duration
    int       m_sel_q, m_fails, m_level, m_secs_total, m_elapsed;
    bit       m_lock, m_oc, m_rel;

    lockout_guard #(
        .MAX_FAILS  (C_MAX_FAILS),
        .TICK_DIV   (C_TICK_DIV),
        .LOCKOUT_SEC(C_LOCK_SEC),
        .BLINK_DIV  (C_BLINK_DIV)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_open_close   (i_open_close),
        .i_selector     (i_selector),
        .i_alarm        (i_alarm),
        .o_open_close   (o_open_close),
        .o_alarm        (o_alarm),
        .o_lockout      (o_lockout),
        .o_release      (o_release),
        .o_seconds_left (o_seconds_left),
        .o_fail_count   (o_fail_count),
        .o_lockout_level(o_lockout_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sel_q = 0; m_fails = 0; m_level = 0; m_secs_total = 0; m_elapsed = 0;
        m_lock = 0; m_oc = 0; m_rel = 0;
    endtask

    function automatic int exp_secs();
        return m_lock ? (m_secs_total - m_elapsed / C_TICK_DIV) : 0;
    endfunction

    function automatic bit exp_alarm(input bit al);
        return al | (m_lock && ((m_elapsed / C_BLINK_DIV) % 2 == 0));
    endfunction

    task automatic model_step(input bit oc, input int sel);
        bit fe, pe, trig;
        fe = (sel == 7) && (m_sel_q != 7);
        pe = (sel == 6) && (m_sel_q != 6);
        trig = 0;
        m_rel = 0;
        m_oc  = 0;
        if (!m_lock) begin
            if (fe) begin
                if (m_fails + 1 == C_MAX_FAILS) begin
                    trig = 1;
                    m_lock = 1;
                    m_elapsed = 0;
                    m_secs_total = C_LOCK_SEC * (2 ** m_level);
                    m_fails = 0;
                    m_level = (m_level < 3) ? m_level + 1 : 3;
                end else begin
                    m_fails++;
                end
            end else if (pe) begin
                m_fails = 0;
                m_level = 0;
            end
            m_oc = oc && !trig;
        end else begin
            m_elapsed++;
            if (m_elapsed == m_secs_total * C_TICK_DIV) begin
                m_lock = 0;
                m_rel  = 1;
            end
        end
        m_sel_q = sel;
    endtask

    task automatic check_regs();
        check("open_close", o_open_close, m_oc);
        check("lockout", o_lockout, m_lock);
        check("release", o_release, m_rel);
        check("seconds_left", o_seconds_left, exp_secs());
        check("fail_count", o_fail_count, m_fails);
        check("lockout_level", o_lockout_level, m_level);
    endtask

    task automatic tick(input bit oc, input logic [2:0] sel, input bit al);
        i_open_close = oc;
        i_selector   = sel;
        i_alarm      = al;
        #1 check("alarm", o_alarm, exp_alarm(al));
        @(posedge clk);
        model_step(oc, int'(sel));
        #1 check_regs();
    endtask

    task automatic do_reset();
        i_alarm      = 1'b0;
        i_open_close = 1'b0;
        rst_n        = 1'b0;
        model_reset();
        #1;
        check("rst_async_lockout", o_lockout, 0);
        check("rst_async_secs", o_seconds_left, 0);
        check("rst_async_level", o_lockout_level, 0);
        check("rst_async_fails", o_fail_count, 0);
        check("rst_async_alarm", o_alarm, 0);
        check("rst_async_oc", o_open_close, 0);
        check("rst_async_rel", o_release, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_regs();
    endtask

    task automatic three_fails(input bit oc_last);
        tick(0, 3'b111, 0); tick(0, 3'b000, 0);
        tick(0, 3'b111, 0); tick(0, 3'b000, 0);
        tick(oc_last, 3'b111, 0);
    endtask

    task automatic run_lockout(input int exp_len, input string tag);
        int len;
        len = o_lockout ? 1 : 0;
        for (int k = 0; k < 300 && o_lockout; k++) begin
            tick(bit'($urandom_range(0, 1)), 3'b000, 0);
            if (o_lockout) len++;
        end
        check({tag, "_len"}, len, exp_len);
        check({tag, "_release"}, o_release, 1);
        check({tag, "_secs_end"}, o_seconds_left, 0);
        tick(0, 3'b000, 0);
        check({tag, "_release_drop"}, o_release, 0);
    endtask

    initial begin
        model_reset();
        #2 do_reset();

        // Pass-through
        tick(1, 3'b000, 0);
        check("pt_oc_high", o_open_close, 1);
        check("pt_fails", o_fail_count, 0);
        tick(0, 3'b000, 0);
        check("pt_oc_low", o_open_close, 0);

        // Failure counting and clear
        tick(0, 3'b111, 0); tick(0, 3'b000, 0);
        tick(0, 3'b111, 0); tick(0, 3'b000, 0);
        check("two_fails", o_fail_count, 2);
        check("two_fails_nolock", o_lockout, 0);
        tick(0, 3'b110, 0);
        check("pass_clear", o_fail_count, 0);
        tick(0, 3'b000, 0);

        // First lockout with coincident button pulse
        three_fails(1);
        check("l1_lock", o_lockout, 1);
        check("l1_secs", o_seconds_left, 2);
        check("l1_level", o_lockout_level, 1);
        check("l1_oc_suppressed", o_open_close, 0);
        run_lockout(8, "l1");

        // Escalation
        three_fails(0);
        check("l2_secs", o_seconds_left, 4);
        check("l2_level", o_lockout_level, 2);
        run_lockout(16, "l2");
        three_fails(0);
        check("l3_secs", o_seconds_left, 8);
        run_lockout(32, "l3");
        three_fails(0);
        check("l4_secs", o_seconds_left, 16);
        check("l4_level", o_lockout_level, 3);
        run_lockout(64, "l4");
        tick(0, 3'b110, 0);
        check("pass_level_clear", o_lockout_level, 0);
        tick(0, 3'b000, 0);

        // Held fail selector counts once
        for (int k = 0; k < 20; k++) tick(0, 3'b111, 0);
        check("held_fail", o_fail_count, 1);
        tick(0, 3'b110, 0);
        tick(0, 3'b000, 0);

        // Reset in the middle of a lockout
        three_fails(0);
        tick(0, 3'b000, 0);
        tick(0, 3'b000, 0);
        check("mid_lock", o_lockout, 1);
        do_reset();
        check("reset_level", o_lockout_level, 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            int r;
            logic [2:0] sel;
            r = $urandom_range(0, 9);
            if (r < 4)       sel = i_selector;
            else if (r < 6)  sel = 3'b111;
            else if (r == 6) sel = 3'b110;
            else             sel = 3'($urandom_range(0, 5));
            if ($urandom_range(0, 499) == 0) do_reset();
            tick(bit'($urandom_range(0, 3) == 0), sel, bit'($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
